// File: rtl/sel_arb4_if.sv
// rtl/sel_arb4_if.sv - request/grant and selector bus of the 4-way arbitrated selector
// Signals:
//   REQ[3:0]        request lines, bit i asks for selector input i (0=A .. 3=D)
//   A, B, C, D      selector data inputs
//   GNT[3:0]        one-hot grant, zero when idle
//   SEL[1:0]        index of the granted input, held while idle
//   VALID           high whenever GNT is non-zero
//   OUT             selected data input, 0 while idle
// Modports: master = requester/data side, slave = arbiter side.
interface sel_arb4_if;
    logic [3:0] REQ;
    logic       A;
    logic       B;
    logic       C;
    logic       D;
    logic [3:0] GNT;
    logic [1:0] SEL;
    logic       VALID;
    logic       OUT;

    modport master (
        output REQ, A, B, C, D,
        input  GNT, SEL, VALID, OUT
    );

    modport slave (
        input  REQ, A, B, C, D,
        output GNT, SEL, VALID, OUT
    );
endinterface

// File: rtl/sel_arb4.sv
// rtl/sel_arb4.sv - round-robin arbiter with bounded hold driving a shared 4-1 selector
// Ports:
//   CK     rising-edge clock
//   RES_N  asynchronous active-low reset
//   bus    sel_arb4_if.slave: REQ/A..D in, GNT/SEL/VALID/OUT out
// Parameter HOLD_MAX (1..15): longest run of consecutive grant cycles while
// another requester is waiting.
module sel_arb4 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       CK,
    input  logic       RES_N,
    sel_arb4_if.slave  bus
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [3:0] HLIM = 4'(HOLD_MAX - 1);

    state_t     state, state_nx;
    logic [1:0] owner, owner_nx;
    logic [1:0] ptr, ptr_nx;
    logic [3:0] hcnt, hcnt_nx;

    logic [3:0] others;
    logic [1:0] pick_all;
    logic [1:0] pick_oth;

    logic [3:0] gnt;
    logic       valid;
    logic       out;

    // First set bit of m searched from p upward, wrapping mod 4.
    // Scanning downward lets the nearest hit overwrite farther ones.
    function automatic logic [1:0] rr_pick(input logic [3:0] m, input logic [1:0] p);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (m[idx]) rr_pick = idx;
        end
    endfunction

    assign others   = bus.REQ & ~(4'b0001 << owner);
    assign pick_all = rr_pick(bus.REQ, ptr);
    assign pick_oth = rr_pick(others, ptr);

    always_ff @(posedge CK or negedge RES_N) begin
        if (!RES_N) begin
            state <= IDLE;
            owner <= 2'd0;
            ptr   <= 2'd0;
            hcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            owner <= owner_nx;
            ptr   <= ptr_nx;
            hcnt  <= hcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        ptr_nx   = ptr;
        hcnt_nx  = hcnt;
        case (state)
            IDLE: begin
                if (|bus.REQ) begin
                    state_nx = OWN;
                    owner_nx = pick_all;
                    ptr_nx   = pick_all + 2'd1;
                    hcnt_nx  = 4'd0;
                end
            end
            OWN: begin
                if (bus.REQ[owner]) begin
                    if (others == 4'd0) begin
                        // Sole requester: keep counting so a newcomer is
                        // served at once if the owner has already had its share.
                        if (hcnt < HLIM) hcnt_nx = hcnt + 4'd1;
                    end else if (hcnt < HLIM) begin
                        hcnt_nx = hcnt + 4'd1;
                    end else begin
                        owner_nx = pick_oth;
                        ptr_nx   = pick_oth + 2'd1;
                        hcnt_nx  = 4'd0;
                    end
                end else if (others != 4'd0) begin
                    owner_nx = pick_oth;
                    ptr_nx   = pick_oth + 2'd1;
                    hcnt_nx  = 4'd0;
                end else begin
                    // Owner and PTR kept so SEL holds its last value.
                    state_nx = IDLE;
                    hcnt_nx  = 4'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt   = 4'd0;
        valid = 1'b0;
        out   = 1'b0;
        if (state == OWN) begin
            gnt   = 4'b0001 << owner;
            valid = 1'b1;
            case (owner)
                2'd0:    out = bus.A;
                2'd1:    out = bus.B;
                2'd2:    out = bus.C;
                default: out = bus.D;
            endcase
        end
    end

    assign bus.GNT   = gnt;
    assign bus.SEL   = owner;
    assign bus.VALID = valid;
    assign bus.OUT   = out;

endmodule

// File: tb/tb_sel_arb4.sv
// tb/tb_sel_arb4.sv - directed and randomized self-checking bench for sel_arb4
module tb_sel_arb4;

    logic       CK = 1'b0;
    logic       RES_N = 1'b0;
    logic [3:0] req = 4'd0;
    logic       da = 1'b0;
    logic       db = 1'b0;
    logic       dc = 1'b0;
    logic       dd = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    sel_arb4_if if1 ();
    sel_arb4_if if4 ();
    sel_arb4_if if15 ();

    assign if1.REQ = req;
    assign if1.A = da;
    assign if1.B = db;
    assign if1.C = dc;
    assign if1.D = dd;
    assign if4.REQ = req;
    assign if4.A = da;
    assign if4.B = db;
    assign if4.C = dc;
    assign if4.D = dd;
    assign if15.REQ = req;
    assign if15.A = da;
    assign if15.B = db;
    assign if15.C = dc;
    assign if15.D = dd;

    sel_arb4 #(.HOLD_MAX(1))  u1  (.CK(CK), .RES_N(RES_N), .bus(if1.slave));
    sel_arb4 #(.HOLD_MAX(4))  u4  (.CK(CK), .RES_N(RES_N), .bus(if4.slave));
    sel_arb4 #(.HOLD_MAX(15)) u15 (.CK(CK), .RES_N(RES_N), .bus(if15.slave));

    logic [3:0] g_a [3];
    logic [1:0] s_a [3];
    logic       v_a [3];
    logic       o_a [3];
    assign g_a[0] = if1.GNT;
    assign g_a[1] = if4.GNT;
    assign g_a[2] = if15.GNT;
    assign s_a[0] = if1.SEL;
    assign s_a[1] = if4.SEL;
    assign s_a[2] = if15.SEL;
    assign v_a[0] = if1.VALID;
    assign v_a[1] = if4.VALID;
    assign v_a[2] = if15.VALID;
    assign o_a[0] = if1.OUT;
    assign o_a[1] = if4.OUT;
    assign o_a[2] = if15.OUT;

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CK);
        RES_N = 1'b0;
        @(negedge CK);
        RES_N = 1'b1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        {da, db, dc, dd} = 4'b1111;
        RES_N = 1'b0;
        tick();
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", if4.GNT); end
        n_checks++;
        if (if4.VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if4.VALID); end
        n_checks++;
        if (if4.SEL !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", if4.SEL); end
        n_checks++;
        if (if4.OUT !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b want 0", if4.OUT); end
        @(negedge CK);
        RES_N = 1'b1;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0001) begin n_fail++; $display("FAIL reset_first_edge got %b want 0001", if4.GNT); end
    endtask

    task automatic test_single();
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        {dd, dc, db, da} = 4'b1011;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", if4.GNT); end
        n_checks++;
        if (if4.SEL !== 2'd2) begin n_fail++; $display("FAIL single_sel got %0d want 2", if4.SEL); end
        n_checks++;
        if (if4.VALID !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", if4.VALID); end
        n_checks++;
        if (if4.OUT !== 1'b0) begin n_fail++; $display("FAIL single_out_lo got %b want 0", if4.OUT); end
        dc = 1'b1;
        da = 1'b0;
        #1;
        n_checks++;
        if (if4.OUT !== 1'b1) begin n_fail++; $display("FAIL single_out_hi got %b want 1", if4.OUT); end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (if4.GNT !== 4'b0100) begin n_fail++; $display("FAIL single_hold cyc %0d got %b want 0100", i, if4.GNT); end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % 4);
            for (int c = 0; c < 4; c++) begin
                tick();
                n_checks++;
                if (if4.GNT !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_all grant %0d cyc %0d got %b want %b", g, c, if4.GNT, exp_g);
                end
            end
        end
    endtask

    task automatic test_handover();
        logic [3:0] exp_seq [9];
        exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                    4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010};
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0001) begin n_fail++; $display("FAIL handover_start got %b want 0001", if4.GNT); end
        req = 4'b1010;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if (if4.GNT !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL handover cyc %0d got %b want %b", i, if4.GNT, exp_seq[i]);
            end
        end
    endtask

    task automatic test_idle_wrap();
        req = 4'b0000;
        do_reset();
        req = 4'b1000;
        {dd, dc, db, da} = 4'b1111;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b1000) begin n_fail++; $display("FAIL idle_own3 got %b want 1000", if4.GNT); end
        req = 4'b0000;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt got %b want 0000", if4.GNT); end
        n_checks++;
        if (if4.VALID !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", if4.VALID); end
        n_checks++;
        if (if4.OUT !== 1'b0) begin n_fail++; $display("FAIL idle_out got %b want 0", if4.OUT); end
        n_checks++;
        if (if4.SEL !== 2'd3) begin n_fail++; $display("FAIL idle_sel got %0d want 3", if4.SEL); end
        tick();
        n_checks++;
        if (if4.SEL !== 2'd3) begin n_fail++; $display("FAIL idle_sel_hold got %0d want 3", if4.SEL); end
        req = 4'b1111;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0001) begin n_fail++; $display("FAIL idle_wrap got %b want 0001", if4.GNT); end
    endtask

    task automatic test_async_reset();
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        {dd, dc, db, da} = 4'b1111;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0100) begin n_fail++; $display("FAIL async_pre got %b want 0100", if4.GNT); end
        #2;
        RES_N = 1'b0;
        #1;
        n_checks++;
        if (if4.GNT !== 4'b0000) begin n_fail++; $display("FAIL async_gnt got %b want 0000", if4.GNT); end
        n_checks++;
        if (if4.SEL !== 2'd0) begin n_fail++; $display("FAIL async_sel got %0d want 0", if4.SEL); end
        n_checks++;
        if (if4.OUT !== 1'b0) begin n_fail++; $display("FAIL async_out got %b want 0", if4.OUT); end
        n_checks++;
        if (if4.VALID !== 1'b0) begin n_fail++; $display("FAIL async_valid got %b want 0", if4.VALID); end
        #1;
        RES_N = 1'b1;
        req = 4'b1100;
        tick();
        n_checks++;
        if (if4.GNT !== 4'b0100) begin n_fail++; $display("FAIL async_after got %b want 0100", if4.GNT); end
    endtask

    task automatic test_hold1();
        logic [3:0] exp_g;
        req = 4'b0000;
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            n_checks++;
            if (if1.GNT !== exp_g) begin
                n_fail++;
                $display("FAIL hold1 cyc %0d got %b want %b", i, if1.GNT, exp_g);
            end
        end
    endtask

    task automatic test_random();
        int         hm [3];
        int         waitc [3][4];
        logic [3:0] prev_req;
        logic [3:0] dat;
        logic [3:0] gk;
        hm = '{1, 4, 15};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                waitc[k][i] = 0;
        req = 4'b0000;
        do_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) req[i] = ($urandom_range(7, 0) != 0);
            if ($urandom_range(31, 0) == 0) req = 4'b0000;
            dat = 4'($urandom_range(15, 0));
            {dd, dc, db, da} = dat;
            prev_req = req;
            tick();
            for (int k = 0; k < 3; k++) begin
                gk = g_a[k];
                n_checks++;
                if ($countones(gk) > 1) begin
                    n_fail++;
                    $display("FAIL rnd_onehot h%0d cyc %0d got %b want at most one bit", hm[k], cyc, gk);
                end
                n_checks++;
                if ((gk & ~prev_req) !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rnd_unreq h%0d cyc %0d got %b want subset of %b", hm[k], cyc, gk, prev_req);
                end
                n_checks++;
                if (v_a[k] !== (gk != 4'b0000)) begin
                    n_fail++;
                    $display("FAIL rnd_valid h%0d cyc %0d got %b want %b", hm[k], cyc, v_a[k], (gk != 4'b0000));
                end
                n_checks++;
                if (v_a[k] && (o_a[k] !== dat[s_a[k]] || gk !== (4'b0001 << s_a[k]))) begin
                    n_fail++;
                    $display("FAIL rnd_out h%0d cyc %0d got out %b gnt %b want out %b for sel %0d",
                             hm[k], cyc, o_a[k], gk, dat[s_a[k]], s_a[k]);
                end
                for (int i = 0; i < 4; i++) begin
                    if (prev_req[i] && !gk[i]) waitc[k][i]++;
                    else waitc[k][i] = 0;
                    n_checks++;
                    if (waitc[k][i] > 3 * hm[k] + 3) begin
                        n_fail++;
                        $display("FAIL rnd_starve h%0d req %0d cyc %0d got wait %0d want <= %0d",
                                 hm[k], i, cyc, waitc[k][i], 3 * hm[k] + 3);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_handover();
        test_idle_wrap();
        test_async_reset();
        test_hold1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
